sum_ctrl_sequencer: RTL and testbench

Command-driven sequencer for the CoRAM sum datapath.
- Pops a two-word command (start address, word count) from the control-thread channel.
- Streams reads through the single-port CoRAM memory and accumulates the words.
- Writes the sum back to memory just past the block, then returns the sum to the thread over the channel.
- Sits in userlogic between the CoRAM channel and the 1-port memory; it is the sole master of both.

---
 rtl/sum_ctrl_pkg.sv | 18 +
 rtl/sum_ctrl_sequencer.sv | 151 +++++++++++++++
 tb/tb_sum_ctrl_sequencer.sv | 277 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/sum_ctrl_pkg.sv
// Shared types and constants for the CoRAM sum control sequencer.
package sum_ctrl_pkg;

    // Sequencer states, from command fetch through response.
    typedef enum logic [2:0] {
        IDLE,
        GET_LEN,
        READ,
        DRAIN,
        WRITE,
        RESP
    } state_t;

    // Position of each word within a two-word command.
    localparam int CMD_ADDR = 0;
    localparam int CMD_LEN  = 1;

endpackage

// File: rtl/sum_ctrl_sequencer.sv
// Command-driven sequencer: pops (start, count) from the thread channel,
// sums count words from the single-port memory, writes the sum just past
// the block and returns it to the thread.
module sum_ctrl_sequencer #(
    parameter int W_A   = 13,
    parameter int W_D   = 32,
    parameter int W_CNT = 16
) (
    input  logic             CLK,
    input  logic             RST_N,
    output logic [W_A-1:0]   mem_addr,
    output logic [W_D-1:0]   mem_d,
    output logic             mem_we,
    input  logic [W_D-1:0]   mem_q,
    output logic [W_D-1:0]   comm_d,
    output logic             comm_enq,
    input  logic             comm_full,
    input  logic [W_D-1:0]   comm_q,
    output logic             comm_deq,
    input  logic             comm_empty,
    output logic             busy,
    output logic [W_CNT-1:0] done_count
);

    import sum_ctrl_pkg::*;

    state_t             state_q;
    state_t             state_d;
    logic [W_A-1:0]     start_q;
    logic [W_A-1:0]     n_q;
    logic [W_A-1:0]     ptr_q;
    logic [W_A-1:0]     rem_q;
    logic [W_D-1:0]     acc_q;
    logic               rd_valid_q;
    logic [W_CNT-1:0]   done_count_q;
    logic [W_A-1:0]     cmd_field;

    // Only the low address bits of a command word carry meaning.
    assign cmd_field = comm_q[W_A-1:0];

    logic unused_cmd_hi;
    assign unused_cmd_hi = &{1'b0, comm_q[W_D-1:W_A]};

    assign busy       = (state_q != IDLE);
    assign done_count = done_count_q;

    // Next-state and output decode; handshakes are held off during reset
    // so no command word is consumed while the block is being cleared.
    always_comb begin
        state_d  = state_q;
        mem_addr = '0;
        mem_d    = '0;
        mem_we   = 1'b0;
        comm_d   = '0;
        comm_deq = 1'b0;
        comm_enq = 1'b0;
        case (state_q)
            IDLE: begin
                if (!comm_empty && RST_N) begin
                    comm_deq = 1'b1;
                    state_d  = GET_LEN;
                end
            end
            GET_LEN: begin
                if (!comm_empty && RST_N) begin
                    comm_deq = 1'b1;
                    state_d  = (cmd_field == '0) ? WRITE : READ;
                end
            end
            READ: begin
                mem_addr = ptr_q;
                if (rem_q == W_A'(1)) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                state_d = WRITE;
            end
            WRITE: begin
                mem_addr = start_q + n_q;
                mem_d    = acc_q;
                mem_we   = 1'b1;
                state_d  = RESP;
            end
            RESP: begin
                comm_d = acc_q;
                if (!comm_full && RST_N) begin
                    comm_enq = 1'b1;
                    state_d  = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Command capture, read pointer, accumulator and completion counter.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            start_q      <= '0;
            n_q          <= '0;
            ptr_q        <= '0;
            rem_q        <= '0;
            acc_q        <= '0;
            rd_valid_q   <= 1'b0;
            done_count_q <= '0;
        end else begin
            rd_valid_q <= (state_q == READ);
            if (rd_valid_q) begin
                acc_q <= acc_q + mem_q;
            end
            case (state_q)
                IDLE: begin
                    if (comm_deq) begin
                        start_q <= cmd_field;
                    end
                end
                GET_LEN: begin
                    if (comm_deq) begin
                        n_q   <= cmd_field;
                        rem_q <= cmd_field;
                        ptr_q <= start_q;
                        acc_q <= '0;
                    end
                end
                READ: begin
                    ptr_q <= ptr_q + W_A'(1);
                    rem_q <= rem_q - W_A'(1);
                end
                RESP: begin
                    if (comm_enq) begin
                        done_count_q <= done_count_q + W_CNT'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sum_ctrl_sequencer.sv
// Directed testbench for sum_ctrl_sequencer with a 1-port memory model,
// a command FIFO and a response capture.
module tb_sum_ctrl_sequencer;

    logic        CLK = 1'b0;
    logic        RST_N;
    logic [12:0] mem_addr;
    logic [31:0] mem_d;
    logic        mem_we;
    logic [31:0] mem_q;
    logic [31:0] comm_d;
    logic        comm_enq;
    logic        comm_full;
    logic [31:0] comm_q;
    logic        comm_deq;
    logic        comm_empty;
    logic        busy;
    logic [15:0] done_count;

    sum_ctrl_sequencer #(.W_A(13), .W_D(32), .W_CNT(16)) dut (
        .CLK        (CLK),
        .RST_N      (RST_N),
        .mem_addr   (mem_addr),
        .mem_d      (mem_d),
        .mem_we     (mem_we),
        .mem_q      (mem_q),
        .comm_d     (comm_d),
        .comm_enq   (comm_enq),
        .comm_full  (comm_full),
        .comm_q     (comm_q),
        .comm_deq   (comm_deq),
        .comm_empty (comm_empty),
        .busy       (busy),
        .done_count (done_count)
    );

    always #5 CLK = ~CLK;

    logic [31:0] mem [0:8191];
    logic        tb_we;
    logic [12:0] tb_addr;
    logic [31:0] tb_wdata;

    logic [31:0] cmd_buf [0:63];
    int          cmd_wr = 0;
    int          cmd_rd = 0;

    int          cycle = 0;
    int          last_deq_cycle = 0;
    int          deq_bad = 0;
    int          enq_bad = 0;
    int          resp_cnt = 0;
    int          resp_cyc = 0;
    int          write_count = 0;
    logic [31:0] resp_val [0:31];

    int          checks = 0;
    int          errors = 0;

    assign comm_empty = (cmd_rd == cmd_wr);
    assign comm_q     = cmd_buf[cmd_rd[5:0]];

    // Single-port memory with one-cycle read latency and a preload port.
    always @(posedge CLK) begin
        if (tb_we) begin
            mem[tb_addr] <= tb_wdata;
        end else if (mem_we) begin
            mem[mem_addr] <= mem_d;
            write_count   <= write_count + 1;
        end
        mem_q <= mem[mem_addr];
    end

    // Channel model: pops commands, captures responses, flags protocol misuse.
    always @(posedge CLK) begin
        cycle <= cycle + 1;
        if (comm_deq) begin
            if (comm_empty) begin
                deq_bad <= deq_bad + 1;
            end else begin
                cmd_rd         <= cmd_rd + 1;
                last_deq_cycle <= cycle;
            end
        end
        if (comm_enq) begin
            if (comm_full) begin
                enq_bad <= enq_bad + 1;
            end else begin
                resp_val[resp_cnt[4:0]] <= comm_d;
                resp_cyc                <= cycle;
                resp_cnt                <= resp_cnt + 1;
            end
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [31:0] word);
        cmd_buf[cmd_wr[5:0]] = word;
        cmd_wr++;
    endtask

    task automatic preload(input logic [12:0] addr, input logic [31:0] data);
        tb_we    = 1'b1;
        tb_addr  = addr;
        tb_wdata = data;
        @(negedge CLK);
    endtask

    task automatic waitCycles(input int n);
        for (int i = 0; i < n; i++) @(negedge CLK);
    endtask

    task automatic waitResponse(input int target);
        int k;
        k = 0;
        while (resp_cnt < target && k < 200) begin
            @(negedge CLK);
            k++;
        end
        checkOutput("response_arrived", resp_cnt, target);
    endtask

    int wc_before;
    int rc_before;

    initial begin
        RST_N     = 1'b0;
        comm_full = 1'b0;
        tb_we     = 1'b0;
        tb_addr   = '0;
        tb_wdata  = '0;
        @(negedge CLK);

        preload(13'h0010, 32'd1);
        preload(13'h0011, 32'd2);
        preload(13'h0012, 32'd3);
        preload(13'h0013, 32'd4);
        preload(13'h0014, 32'h0000_0BAD);
        preload(13'h0020, 32'h0000_DEAD);
        preload(13'h1FFE, 32'hFFFF_FFFF);
        preload(13'h1FFF, 32'd2);
        preload(13'h0000, 32'd0);
        preload(13'h0001, 32'd0);
        preload(13'h0002, 32'h0000_0BAD);
        preload(13'h0100, 32'd5);
        preload(13'h0101, 32'd5);
        preload(13'h0102, 32'd5);
        preload(13'h0103, 32'd5);
        preload(13'h0104, 32'h0000_0055);
        preload(13'h0200, 32'd10);
        preload(13'h0201, 32'd20);
        preload(13'h0202, 32'd30);
        preload(13'h0300, 32'd7);
        preload(13'h0301, 32'd8);
        tb_we = 1'b0;

        $display("[TB] reset state");
        checkOutput("rst_busy", {31'd0, busy}, 32'd0);
        checkOutput("rst_mem_we", {31'd0, mem_we}, 32'd0);
        checkOutput("rst_comm_enq", {31'd0, comm_enq}, 32'd0);
        checkOutput("rst_comm_deq", {31'd0, comm_deq}, 32'd0);
        checkOutput("rst_mem_addr", {19'd0, mem_addr}, 32'd0);
        checkOutput("rst_outs_d", mem_d | comm_d, 32'd0);
        checkOutput("rst_done_count", {16'd0, done_count}, 32'd0);
        RST_N = 1'b1;
        @(negedge CLK);

        $display("[TB] test 1: directed sum");
        applyStimulus(32'h0000_0010);
        applyStimulus(32'd4);
        waitResponse(1);
        checkOutput("t1_resp", resp_val[0], 32'd10);
        checkOutput("t1_latency", resp_cyc - last_deq_cycle, 32'd7);
        checkOutput("t1_mem_wb", mem[13'h0014], 32'd10);
        checkOutput("t1_done_count", {16'd0, done_count}, 32'd1);
        waitCycles(3);
        checkOutput("t1_no_dup", resp_cnt, 32'd1);
        checkOutput("t1_idle", {31'd0, busy}, 32'd0);

        $display("[TB] test 2: zero length");
        applyStimulus(32'h0000_0020);
        applyStimulus(32'd0);
        waitResponse(2);
        checkOutput("t2_resp", resp_val[1], 32'd0);
        checkOutput("t2_latency", resp_cyc - last_deq_cycle, 32'd2);
        checkOutput("t2_mem_wb", mem[13'h0020], 32'd0);
        checkOutput("t2_done_count", {16'd0, done_count}, 32'd2);

        $display("[TB] test 3: wrap and overflow");
        applyStimulus(32'h0000_1FFE);
        applyStimulus(32'd4);
        waitResponse(3);
        checkOutput("t3_resp", resp_val[2], 32'd1);
        checkOutput("t3_mem_wb", mem[13'h0002], 32'd1);
        checkOutput("t3_src_intact", mem[13'h1FFE], 32'hFFFF_FFFF);
        checkOutput("t3_done_count", {16'd0, done_count}, 32'd3);

        $display("[TB] test 4a: response backpressure");
        comm_full = 1'b1;
        applyStimulus(32'h0000_0010);
        applyStimulus(32'd4);
        waitCycles(10);
        for (int i = 0; i < 5; i++) begin
            checkOutput("t4_enq_held", {31'd0, comm_enq}, 32'd0);
            checkOutput("t4_d_stable", comm_d, 32'd10);
            @(negedge CLK);
        end
        checkOutput("t4_none_yet", resp_cnt, 32'd3);
        comm_full = 1'b0;
        waitResponse(4);
        waitCycles(5);
        checkOutput("t4_single_resp", resp_cnt, 32'd4);
        checkOutput("t4_resp", resp_val[3], 32'd10);
        checkOutput("t4_enq_while_full", enq_bad, 32'd0);
        checkOutput("t4_done_count", {16'd0, done_count}, 32'd4);

        $display("[TB] test 4b: gap between command words");
        applyStimulus(32'h0000_0010);
        waitCycles(5);
        checkOutput("t4b_busy_wait", {31'd0, busy}, 32'd1);
        checkOutput("t4b_no_deq", {31'd0, comm_deq}, 32'd0);
        checkOutput("t4b_no_mem_we", {31'd0, mem_we}, 32'd0);
        applyStimulus(32'd4);
        waitResponse(5);
        checkOutput("t4b_resp", resp_val[4], 32'd10);
        checkOutput("t4b_latency", resp_cyc - last_deq_cycle, 32'd7);
        checkOutput("t4b_done_count", {16'd0, done_count}, 32'd5);

        $display("[TB] test 5: reset mid-read");
        wc_before = write_count;
        rc_before = resp_cnt;
        applyStimulus(32'h0000_0100);
        applyStimulus(32'd4);
        waitCycles(3);
        checkOutput("t5_in_read", {31'd0, busy}, 32'd1);
        checkOutput("t5_read_addr", {19'd0, mem_addr}, 32'h0000_0101);
        RST_N = 1'b0;
        @(negedge CLK);
        checkOutput("t5_busy", {31'd0, busy}, 32'd0);
        checkOutput("t5_mem_addr", {19'd0, mem_addr}, 32'd0);
        checkOutput("t5_strobes", {29'd0, mem_we, comm_enq, comm_deq}, 32'd0);
        checkOutput("t5_outs_d", mem_d | comm_d, 32'd0);
        checkOutput("t5_done_count", {16'd0, done_count}, 32'd0);
        RST_N = 1'b1;
        waitCycles(15);
        checkOutput("t5_no_write", write_count - wc_before, 32'd0);
        checkOutput("t5_no_resp", resp_cnt - rc_before, 32'd0);
        checkOutput("t5_mem_intact", mem[13'h0104], 32'h0000_0055);
        checkOutput("t5_done_after", {16'd0, done_count}, 32'd0);

        $display("[TB] test 6: back-to-back commands");
        rc_before = resp_cnt;
        applyStimulus(32'h0000_0200);
        applyStimulus(32'd3);
        applyStimulus(32'h0000_0300);
        applyStimulus(32'd2);
        waitResponse(rc_before + 2);
        checkOutput("t6_resp_first", resp_val[rc_before], 32'd60);
        checkOutput("t6_resp_second", resp_val[rc_before + 1], 32'd15);
        checkOutput("t6_mem_first", mem[13'h0203], 32'd60);
        checkOutput("t6_mem_second", mem[13'h0302], 32'd15);
        checkOutput("t6_done_count", {16'd0, done_count}, 32'd2);
        checkOutput("t6_deq_while_empty", deq_bad, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
